// File: rtl/ball_hit_ctrl_if.sv
// Signal bundle between the ball pixel pipeline / game control and ball_hit_ctrl.
// The slave modport is the controller's view; master is the driver side.
interface ball_hit_ctrl_if;
    logic        startOfFrame;
    logic        ballDrawReq;
    logic        ropeDrawReq;
    logic        playerDrawReq;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        respawn;
    logic        ballVisible;
    logic        splitPulse;
    logic [10:0] splitX;
    logic [10:0] splitY;
    logic        playerHit;
    logic [1:0]  ballState;

    modport master (
        output startOfFrame, ballDrawReq, ropeDrawReq, playerDrawReq,
               topLeftX, topLeftY, respawn,
        input  ballVisible, splitPulse, splitX, splitY, playerHit, ballState
    );

    modport slave (
        input  startOfFrame, ballDrawReq, ropeDrawReq, playerDrawReq,
               topLeftX, topLeftY, respawn,
        output ballVisible, splitPulse, splitX, splitY, playerHit, ballState
    );
endinterface

// File: rtl/ball_hit_ctrl.sv
// Ball collision detector and life-cycle sequencer (ALIVE -> POP blink -> DEAD).
// Optional post-respawn hit immunity is enabled by defining HIT_GRACE_EN.
module ball_hit_ctrl #(
    parameter int unsigned POP_FRAMES   = 16,
    parameter int unsigned GRACE_FRAMES = 30
) (
    input  logic           clk,
    input  logic           resetN,
    ball_hit_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ALIVE = 2'b00, POP = 2'b01, DEAD = 2'b10} state_t;

`ifdef HIT_GRACE_EN
    localparam logic [7:0] GRACE_LD = 8'(GRACE_FRAMES);
`else
    // Reload of zero keeps the grace counter permanently idle, so it folds away.
    localparam logic [7:0] GRACE_LD = 8'(GRACE_FRAMES) & 8'd0;
`endif
    localparam logic [7:0] POP_LD = 8'(POP_FRAMES);

    state_t      state, state_nxt;
    logic        rope_flag, plyr_flag;
    logic        rope_coin, plyr_coin, sof, grace_act;
    logic [7:0]  pop_cnt, pop_cnt_nxt;
    logic [7:0]  grace_cnt, grace_cnt_nxt;
    logic        vis, vis_nxt;
    logic        split, split_nxt;
    logic        phit, phit_nxt;
    logic [10:0] sx, sx_nxt, sy, sy_nxt;

    assign sof       = bus.startOfFrame;
    assign rope_coin = bus.ballDrawReq & bus.ropeDrawReq;
    assign plyr_coin = bus.ballDrawReq & bus.playerDrawReq;
    assign grace_act = (grace_cnt != 8'd0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= ALIVE;
            rope_flag <= 1'b0;
            plyr_flag <= 1'b0;
            pop_cnt   <= 8'd0;
            grace_cnt <= 8'd0;
            vis       <= 1'b1;
            split     <= 1'b0;
            phit      <= 1'b0;
            sx        <= 11'd0;
            sy        <= 11'd0;
        end else begin
            state     <= state_nxt;
            // On the frame boundary the flags restart from this cycle's coincidence.
            rope_flag <= sof ? rope_coin : (rope_flag | rope_coin);
            plyr_flag <= sof ? plyr_coin : (plyr_flag | plyr_coin);
            pop_cnt   <= pop_cnt_nxt;
            grace_cnt <= grace_cnt_nxt;
            vis       <= vis_nxt;
            split     <= split_nxt;
            phit      <= phit_nxt;
            sx        <= sx_nxt;
            sy        <= sy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ALIVE:   if (sof && !grace_act && rope_flag) state_nxt = POP;
            POP:     if (sof && pop_cnt == 8'd1)         state_nxt = DEAD;
            DEAD:    if (bus.respawn)                    state_nxt = ALIVE;
            default: state_nxt = ALIVE;
        endcase
    end

    always_comb begin
        pop_cnt_nxt   = pop_cnt;
        grace_cnt_nxt = grace_cnt;
        vis_nxt       = vis;
        split_nxt     = 1'b0;
        phit_nxt      = 1'b0;
        sx_nxt        = sx;
        sy_nxt        = sy;
        unique case (state)
            ALIVE: begin
                if (sof) begin
                    if (grace_act) begin
                        grace_cnt_nxt = grace_cnt - 8'd1;
                        vis_nxt       = (grace_cnt == 8'd1) ? 1'b1 : ~vis;
                    end else if (rope_flag) begin
                        split_nxt   = 1'b1;
                        sx_nxt      = bus.topLeftX;
                        sy_nxt      = bus.topLeftY;
                        pop_cnt_nxt = POP_LD;
                        vis_nxt     = 1'b0;
                    end else if (plyr_flag) begin
                        phit_nxt = 1'b1;
                    end
                end
            end
            POP: begin
                if (sof) begin
                    if (pop_cnt != 8'd0) pop_cnt_nxt = pop_cnt - 8'd1;
                    vis_nxt = (pop_cnt == 8'd1) ? 1'b0 : ~vis;
                end
            end
            DEAD: begin
                vis_nxt = bus.respawn;
                if (bus.respawn) grace_cnt_nxt = GRACE_LD;
            end
            default: vis_nxt = 1'b1;
        endcase
    end

    assign bus.ballVisible = vis;
    assign bus.splitPulse  = split;
    assign bus.splitX      = sx;
    assign bus.splitY      = sy;
    assign bus.playerHit   = phit;
    assign bus.ballState   = state;
endmodule

// File: tb/tb_ball_hit_ctrl.sv
// Self-checking bench for ball_hit_ctrl: directed scenarios plus random frames
// checked every cycle against a frame-level reference model.
module tb_ball_hit_ctrl;
    localparam int POP_F = 4;
    localparam int GRACE = 2;
`ifdef HIT_GRACE_EN
    localparam int GRACE_EFF = GRACE;
`else
    localparam int GRACE_EFF = 0;
`endif

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    ball_hit_ctrl_if bus();

    ball_hit_ctrl #(.POP_FRAMES(POP_F), .GRACE_FRAMES(GRACE)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 alive / 1 pop / 2 dead, counted in frames.
    int          m_phase, m_pops, m_gs;
    bit          m_rope, m_plyr;
    bit          e_split, e_phit;
    logic [10:0] e_sx, e_sy;

    task automatic model_reset();
        m_phase = 0; m_pops = 0; m_gs = GRACE_EFF;
        m_rope = 0; m_plyr = 0; e_split = 0; e_phit = 0; e_sx = 0; e_sy = 0;
    endtask

    function automatic bit exp_vis();
        if (m_phase == 0) return (m_gs >= GRACE_EFF) || (m_gs % 2 == 0);
        if (m_phase == 1) return (m_pops % 2 == 1);
        return 1'b0;
    endfunction

    task automatic model_step(input bit s, b, r, p, rs, input logic [10:0] x, y);
        bit rc, pc;
        rc = b & r;
        pc = b & p;
        e_split = 0;
        e_phit  = 0;
        if (m_phase == 2) begin
            if (rs) begin m_phase = 0; m_gs = 0; end
        end else if (s) begin
            if (m_phase == 0) begin
                if (m_gs < GRACE_EFF) m_gs++;
                else if (m_rope) begin
                    e_split = 1; e_sx = x; e_sy = y; m_phase = 1; m_pops = 0;
                end else if (m_plyr) e_phit = 1;
            end else begin
                m_pops++;
                if (m_pops >= POP_F) m_phase = 2;
            end
        end
        m_rope = s ? rc : (m_rope | rc);
        m_plyr = s ? pc : (m_plyr | pc);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ballVisible", 32'(bus.ballVisible), 32'(exp_vis()));
        chk("splitPulse",  32'(bus.splitPulse),  32'(e_split));
        chk("splitX",      32'(bus.splitX),      32'(e_sx));
        chk("splitY",      32'(bus.splitY),      32'(e_sy));
        chk("playerHit",   32'(bus.playerHit),   32'(e_phit));
        chk("ballState",   32'(bus.ballState),   32'(m_phase));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_vis"},   32'(bus.ballVisible), 32'd1);
        chk({tag, "_split"}, 32'(bus.splitPulse),  32'd0);
        chk({tag, "_sx"},    32'(bus.splitX),      32'd0);
        chk({tag, "_sy"},    32'(bus.splitY),      32'd0);
        chk({tag, "_phit"},  32'(bus.playerHit),   32'd0);
        chk({tag, "_state"}, 32'(bus.ballState),   32'd0);
    endtask

    task automatic cyc(input bit s, b, r, p, rs, input logic [10:0] x, y);
        bus.startOfFrame = s; bus.ballDrawReq = b; bus.ropeDrawReq = r;
        bus.playerDrawReq = p; bus.respawn = rs; bus.topLeftX = x; bus.topLeftY = y;
        model_step(s, b, r, p, rs, x, y);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 11'd0, 11'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_vis_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int exp_st_seq  [4] = '{1, 1, 1, 2};
        int hits;

        bus.startOfFrame = 0; bus.ballDrawReq = 0; bus.ropeDrawReq = 0;
        bus.playerDrawReq = 0; bus.respawn = 0; bus.topLeftX = 0; bus.topLeftY = 0;
        model_reset();
        #12;
        check_reset_values("reset");
        resetN = 1'b1;

        // Coincidence on the SOF cycle belongs to the new frame.
        cyc(1, 1, 0, 1, 0, 11'd5, 11'd6);
        chk("sof_boundary_phit", 32'(bus.playerHit), 32'd0);
        idle(4);
        hits = 0;
        cyc(1, 0, 0, 0, 0, 11'd0, 11'd0);
        hits += int'(bus.playerHit);
        for (int f = 0; f < 2; f++) begin
            idle(2);
            cyc(0, 1, 0, 1, 0, 11'd0, 11'd0);
            idle(2);
            cyc(1, 0, 0, 0, 0, 11'd0, 11'd0);
            hits += int'(bus.playerHit);
            idle(1);
            chk("phit_one_cycle", 32'(bus.playerHit), 32'd0);
        end
        chk("phit_count", 32'(hits), 32'd3);
        chk("phit_state", 32'(bus.ballState), 32'd0);

        // Rope and player in the same frame: rope wins.
        idle(2);
        cyc(0, 1, 1, 1, 0, 11'd0, 11'd0);
        idle(1);
        cyc(0, 1, 0, 1, 0, 11'd0, 11'd0);
        cyc(1, 0, 0, 0, 0, 11'd100, 11'd200);
        chk("rope_split",  32'(bus.splitPulse),  32'd1);
        chk("rope_phit",   32'(bus.playerHit),   32'd0);
        chk("rope_sx",     32'(bus.splitX),      32'd100);
        chk("rope_sy",     32'(bus.splitY),      32'd200);
        chk("rope_state",  32'(bus.ballState),   32'd1);
        chk("rope_vis",    32'(bus.ballVisible), 32'd0);
        idle(1);
        chk("split_one_cycle", 32'(bus.splitPulse), 32'd0);

        // Blink through POP with respawn and rope hits ignored.
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 1, 0, 1, 11'd7, 11'd7);
            idle(2);
            cyc(1, 0, 0, 0, 0, 11'd9, 11'd9);
            chk("pop_vis",   32'(bus.ballVisible), 32'(exp_vis_seq[k]));
            chk("pop_state", 32'(bus.ballState),   32'(exp_st_seq[k]));
            chk("pop_split", 32'(bus.splitPulse),  32'd0);
        end
        cyc(0, 1, 1, 0, 0, 11'd1, 11'd1);
        cyc(1, 0, 0, 0, 0, 11'd3, 11'd3);
        chk("dead_no_split", 32'(bus.splitPulse), 32'd0);
        chk("dead_sx_held",  32'(bus.splitX),     32'd100);
        idle(2);
        cyc(0, 0, 0, 0, 1, 11'd0, 11'd0);
        chk("respawn_state", 32'(bus.ballState),   32'd0);
        chk("respawn_vis",   32'(bus.ballVisible), 32'd1);

`ifdef HIT_GRACE_EN
        // First two frames after respawn are immune, the third splits.
        for (int f = 0; f < 3; f++) begin
            idle(1);
            cyc(0, 1, 1, 0, 0, 11'd0, 11'd0);
            cyc(1, 0, 0, 0, 0, 11'd40, 11'd50);
            chk("grace_split", 32'(bus.splitPulse), (f == 2) ? 32'd1 : 32'd0);
        end
`else
        idle(1);
        cyc(0, 1, 1, 0, 0, 11'd0, 11'd0);
        cyc(1, 0, 0, 0, 0, 11'd40, 11'd50);
        chk("post_respawn_split", 32'(bus.splitPulse), 32'd1);
`endif
        cyc(1, 0, 0, 0, 0, 11'd0, 11'd0);
        idle(2);

        // Asynchronous reset in the middle of POP.
        #2;
        resetN = 1'b0;
        #1;
        check_reset_values("midpop_reset");
        model_reset();
        #1;
        resetN = 1'b1;

        for (int i = 0; i < 400; i++) begin
            bit s, b, r, p, rs;
            s  = ($urandom_range(0, 7) == 0);
            b  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 5) == 0);
            p  = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 15) == 0);
            cyc(s, b, r, p, rs, 11'($urandom), 11'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ball_hit_ctrl.md
Name: ball_hit_ctrl

Overview:
- Sits directly downstream of the ball trajectory generator and the per-pixel draw-request logic.
- Detects pixel-level coincidence of the ball with the rope (harpoon) and with the player during each frame.
- Sequences the ball's life cycle: alive, popping (blink), dead.
- Emits a one-cycle split request, carrying the latched ball position, to the ball spawner, plus a one-cycle player-hit pulse to game control.

Parameters:
- POP_FRAMES, 16, number of frames spent in POP before DEAD (1..255).
- GRACE_FRAMES, 30, hit-immunity frames after respawn (used only with HIT_GRACE_EN; 0..255).

Ports:
- clk  in  1  system clock
- resetN  in  1  reset
- startOfFrame  in  1  one-cycle pulse at start of each frame
- ballDrawReq  in  1  current pixel belongs to ball
- ropeDrawReq  in  1  current pixel belongs to rope
- playerDrawReq  in  1  current pixel belongs to player
- topLeftX  in  11  ball top-left X from trajectory generator
- topLeftY  in  11  ball top-left Y from trajectory generator
- respawn  in  1  one-cycle request to revive a dead ball
- ballVisible  out  1  enable for the ball's draw request
- splitPulse  out  1  one-cycle split request
- splitX  out  11  ball X latched at split
- splitY  out  11  ball Y latched at split
- playerHit  out  1  one-cycle player-collision pulse
- ballState  out  2  00=ALIVE, 01=POP, 10=DEAD

Behaviour:
- Reset is asynchronous and active-low on resetN; clock is clk.
- Reset values: state ALIVE, ballVisible=1, splitPulse=0, splitX=0, splitY=0, playerHit=0, frame counter=0, both hit flags=0.
- All outputs are registered.
- Hit flags are sticky within a frame:
  - ropeFlag sets on any cycle where ballDrawReq && ropeDrawReq.
  - plyrFlag sets on any cycle where ballDrawReq && playerDrawReq.
- Frame evaluation happens on the edge where startOfFrame=1:
  - Decisions use the flag values held before that edge.
  - Each flag is then loaded with that cycle's coincidence, not 0, so a hit on the boundary cycle counts toward the new frame.
- Pulse outputs splitPulse and playerHit:
  - They rise in the cycle after the startOfFrame cycle.
  - Each is high for exactly one clk.
  - They are deasserted on every other cycle.
- ALIVE, at frame evaluation:
  - If ropeFlag: splitPulse=1; splitX/splitY capture topLeftX/topLeftY from the startOfFrame cycle; counter=POP_FRAMES; ballVisible=0; go to POP. Rope has priority; plyrFlag in the same frame is discarded and playerHit stays 0.
  - Else if plyrFlag: playerHit=1; remain ALIVE.
- POP, at frame evaluation:
  - Decrement counter and toggle ballVisible.
  - If the counter was 1: go to DEAD with ballVisible=0.
  - Flags are ignored.
- DEAD:
  - ballVisible=0.
  - respawn (any cycle) → ALIVE with ballVisible=1 on the next cycle.
- respawn is ignored in ALIVE and POP.
- splitX/splitY hold their value until the next split.
- Reset mid-POP or mid-frame: immediate return to the reset values; the partial frame's flags are lost.
- Counter width is 8 bits and it never wraps: it decrements only while nonzero.

Optional Feature:
- Macro: HIT_GRACE_EN.
- Defined:
  - Respawn loads a grace counter with GRACE_FRAMES.
  - While the grace counter is nonzero, ALIVE frame evaluation ignores both flags (no split, no playerHit), and ballVisible blinks (toggles each frame).
  - The grace counter decrements each startOfFrame.
  - At 0, ballVisible=1 and normal evaluation resumes.
  - Reset clears the grace counter.
- Undefined: no grace counter; hits are evaluated from the first frame after respawn.

Test Plan:
- Rope hit: ballDrawReq&ropeDrawReq for 1 cycle mid-frame, topLeft=(100,200) at the next startOfFrame → splitPulse high for 1 cycle one clk after the SOF; splitX=100, splitY=200; ballState=01; ballVisible=0.
- Priority: rope and player coincidences in the same frame → splitPulse=1, playerHit never asserted.
- Player hit: only ball&player coincidence over 3 consecutive frames → three single-cycle playerHit pulses; ballState stays 00.
- Pop sequence with POP_FRAMES=4 after a split → ballVisible 1,0,1 on the next three SOFs, then DEAD (10) with ballVisible=0 at the 4th SOF; later rope coincidences produce no splitPulse.
- Boundary and reset: coincidence exactly on the SOF cycle → evaluated at the following SOF, not the current one. Respawn while in POP is ignored; respawn in DEAD → ALIVE, ballVisible=1 next cycle. resetN low mid-POP → all outputs at reset values.
- HIT_GRACE_EN, GRACE_FRAMES=2: rope hit in the two frames after respawn → no split; rope hit in the 3rd frame → splitPulse.
